// File: rtl/m2_pkg.sv
// Shared types and default sizing for the Manchester-II word receiver.
package m2_pkg;

    localparam int M2_HALF_BIT_CLKS = 288;
    localparam int M2_DATA_W        = 16;
    localparam int M2_SYNC_LEN      = 3;

    // Receiver framing states; IDLE must stay at encoding 0 so reset lands there.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SYNC  = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4
    } m2_state_t;

endpackage

// File: rtl/m2_bit_sampler.sv
// Line front end: two-flop synchroniser, edge detector and half-cell sample
// counter. The FSM selects the half-length first interval with start_phase.
module m2_bit_sampler
    import m2_pkg::*;
#(
    parameter int HALF_BIT_CLKS = M2_HALF_BIT_CLKS
) (
    input  logic clock_system,
    input  logic rstn,
    input  logic line_in,
    input  logic start_phase,
    input  logic run,
    input  logic clear,
    output logic line_edge,
    output logic sample_stb,
    output logic sample_val
);

    localparam int SCW = $clog2(HALF_BIT_CLKS);
    localparam logic [SCW-1:0] TERM_FULL = SCW'(HALF_BIT_CLKS - 1);
    localparam logic [SCW-1:0] TERM_HALF = SCW'(HALF_BIT_CLKS / 2 - 1);

    logic           r1_q;
    logic           r2_q;
    logic           r3_q;
    logic [SCW-1:0] cnt_q;
    logic [SCW-1:0] cnt_d;
    logic [SCW-1:0] term;

    assign line_edge  = r2_q ^ r3_q;
    assign sample_val = r2_q;

    // Sample counter: runs to the selected terminal count, strobes, then wraps to 0.
    always_comb begin
        term       = start_phase ? TERM_HALF : TERM_FULL;
        sample_stb = run && (cnt_q == term);
        cnt_d      = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = sample_stb ? '0 : cnt_q + SCW'(1);
        end
    end

    // Synchroniser chain and counter registers.
    always_ff @(posedge clock_system) begin
        if (!rstn) begin
            r1_q  <= 1'b0;
            r2_q  <= 1'b0;
            r3_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            r1_q  <= line_in;
            r2_q  <= r1_q;
            r3_q  <= r2_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m2_rx_decoder.sv
// Manchester-II serial word receiver: sync detection of either polarity,
// mid-cell half-bit sampling, Manchester pair checking and word delivery.
// Optional odd-parity checking is enabled by defining PARITY_CHECK_EN.
module m2_rx_decoder
    import m2_pkg::*;
#(
    parameter int HALF_BIT_CLKS = M2_HALF_BIT_CLKS,
    parameter int DATA_W        = M2_DATA_W,
    parameter int SYNC_LEN      = M2_SYNC_LEN
) (
    input  logic              clock_system,
    input  logic              rstn,
    input  logic              m2_udi,
    output logic [DATA_W-1:0] recv_data,
    output logic              sync_type,
    output logic              rden,
    output logic              man_err,
    output logic              par_err
);

    // Half-bit cells carried by the data phase: data bits plus the parity bit.
    localparam int HB     = 2 * (DATA_W + 1);
    localparam int BCW_DT = $clog2(HB + 1);
    localparam int BCW_SY = $clog2(2 * SYNC_LEN);
    // Bit counter must also index the sync phase when words are very short.
    localparam int BCW    = (BCW_DT > BCW_SY) ? BCW_DT : BCW_SY;
    localparam logic [BCW-1:0] SYNC_FIRST_LAST = BCW'(SYNC_LEN - 1);
    localparam logic [BCW-1:0] SYNC_LAST       = BCW'(2 * SYNC_LEN - 2);
    localparam logic [BCW-1:0] DATA_LAST       = BCW'(HB - 1);

    m2_state_t         state_q, state_d;
    logic              lvl_q, lvl_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [HB-1:0]     half_q, half_d;
    logic              merr_q, merr_d;
    logic [DATA_W-1:0] recv_data_q, recv_data_d;
    logic              sync_type_q, sync_type_d;
    logic              rden_q, rden_d;
    logic              man_err_q, man_err_d;
    logic              par_err_q, par_err_d;

    logic              line_edge;
    logic              sample_stb;
    logic              sample_val;
    logic              sync_expect;
    logic [DATA_W-1:0] data_bits;
    logic              par_fail;

    m2_bit_sampler #(
        .HALF_BIT_CLKS(HALF_BIT_CLKS)
    ) u_sampler (
        .clock_system(clock_system),
        .rstn        (rstn),
        .line_in     (m2_udi),
        .start_phase (state_q == START),
        .run         ((state_q == START) || (state_q == SYNC) || (state_q == DATA)),
        .clear       (state_q == IDLE),
        .line_edge   (line_edge),
        .sample_stb  (sample_stb),
        .sample_val  (sample_val)
    );

    // The first half of every pair carries the bit; the oldest pair is the MSB.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data_bits
        assign data_bits[gi] = half_q[2 * gi + 3];
    end

`ifdef PARITY_CHECK_EN
    assign par_fail = ~(^data_bits ^ half_q[1]);
`else
    assign par_fail = 1'b0;
`endif

    assign recv_data = recv_data_q;
    assign sync_type = sync_type_q;
    assign rden      = rden_q;
    assign man_err   = man_err_q;
    assign par_err   = par_err_q;

    // Framing FSM next-state, shift register and output load logic.
    always_comb begin
        state_d     = state_q;
        lvl_d       = lvl_q;
        bit_cnt_d   = bit_cnt_q;
        half_d      = half_q;
        merr_d      = merr_q;
        recv_data_d = recv_data_q;
        sync_type_d = sync_type_q;
        rden_d      = 1'b0;
        man_err_d   = man_err_q;
        par_err_d   = par_err_q;
        sync_expect = (bit_cnt_q < SYNC_FIRST_LAST) ? lvl_q : ~lvl_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                merr_d    = 1'b0;
                if (line_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_stb) begin
                    lvl_d     = sample_val;
                    bit_cnt_d = '0;
                    state_d   = SYNC;
                end
            end
            SYNC: begin
                if (sample_stb) begin
                    if (sample_val != sync_expect) begin
                        state_d = IDLE;
                    end else if (bit_cnt_q == SYNC_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            DATA: begin
                if (sample_stb) begin
                    half_d = {half_q[HB-2:0], sample_val};
                    // Second half of a pair must differ from the first.
                    if (bit_cnt_q[0] && (sample_val == half_q[0])) begin
                        merr_d = 1'b1;
                    end
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            DONE: begin
                recv_data_d = data_bits;
                sync_type_d = lvl_q;
                man_err_d   = merr_q;
                par_err_d   = par_fail;
                rden_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All decoder state and registered outputs.
    always_ff @(posedge clock_system) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lvl_q       <= 1'b0;
            bit_cnt_q   <= '0;
            half_q      <= '0;
            merr_q      <= 1'b0;
            recv_data_q <= '0;
            sync_type_q <= 1'b0;
            rden_q      <= 1'b0;
            man_err_q   <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            bit_cnt_q   <= bit_cnt_d;
            half_q      <= half_d;
            merr_q      <= merr_d;
            recv_data_q <= recv_data_d;
            sync_type_q <= sync_type_d;
            rden_q      <= rden_d;
            man_err_q   <= man_err_d;
            par_err_q   <= par_err_d;
        end
    end

endmodule
